// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_t;

  localparam int CCFF_SB_1__0_LEN = 46;

  function automatic int ccff_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word register and bit serializer feeding ccff_head; one bit per cycle,
// refilled in the cycle its last bit goes out so back-to-back words have no gap.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              enable_i,
  input  logic              room_i,
  input  logic              last_shift_i,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              ccff_head_o,
  output logic              chain_shift_en_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic              head_q, head_d;
  logic              shift_q, shift_d;
  logic              last_bit, accept;

  // shift_q doubles as "a buffered bit is being presented this cycle"
  assign last_bit  = shift_q && (idx_q == IDX_LAST);
  assign s_ready_o = enable_i && room_i && (!shift_q || last_bit);
  assign accept    = s_valid_i && s_ready_o;
  assign idx_nxt   = idx_q + 1'b1;

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    head_d  = 1'b0;
    shift_d = 1'b0;
    if (!enable_i || last_shift_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (accept) begin
      word_d  = s_data_i;
      idx_d   = '0;
      head_d  = s_data_i[0];
      shift_d = 1'b1;
    end else if (shift_q && !last_bit) begin
      idx_d   = idx_nxt;
      head_d  = word_q[idx_nxt];
      shift_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      word_q  <= '0;
      idx_q   <= '0;
      head_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      shift_q <= shift_d;
    end
  end

  assign ccff_head_o      = head_q;
  assign chain_shift_en_o = shift_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a configuration chain from host words and counts ones read back on ccff_tail.
//   state | meaning
//   IDLE  | waiting for start, chain held
//   LOAD  | accepting words and shifting the chain
//   DONE  | CHAIN_LEN bits shifted, tail_ones valid
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_SB_1__0_LEN,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tail_ones
);

  localparam int N_WORDS = ccff_words(CHAIN_LEN, WORD_W);
  localparam int WA_W    = $clog2(N_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [WA_W-1:0]  WA_MAX   = WA_W'(N_WORDS);

  ccff_state_t      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] tail_q, tail_d;
  logic [WA_W-1:0]  words_q, words_d;
  logic             enable, room, last_shift, clear;

  assign enable     = (state_q == LOAD) && !abort;
  assign room       = words_q < WA_MAX;
  assign last_shift = chain_shift_en && (bit_cnt_q == CNT_LAST);
  assign clear      = start && !abort && (state_q != LOAD);

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk         (prog_clk),
    .pReset           (pReset),
    .enable_i         (enable),
    .room_i           (room),
    .last_shift_i     (last_shift),
    .s_data_i         (s_data),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready),
    .ccff_head_o      (ccff_head),
    .chain_shift_en_o (chain_shift_en)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tail_d    = tail_q;
    words_d   = words_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (last_shift) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    // tail is sampled only while the gated chain clock is enabled
    if (chain_shift_en && (bit_cnt_q != CNT_FULL)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      tail_d    = tail_q + CNT_W'(ccff_tail);
    end
    if (s_valid && s_ready) words_d = words_q + 1'b1;
    if (clear) begin
      bit_cnt_d = '0;
      tail_d    = '0;
      words_d   = '0;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tail_q    <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tail_q    <= tail_d;
      words_q   <= words_d;
    end
  end

  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign tail_ones = tail_q;

endmodule
